sequence_player: RTL

- Reads the 160-bit sequence storage image, i.e. 16 slots of 10-bit Morse sequences, and plays it back as a timed on/off tone for the LED/buzzer driver.
- It is the read-out end of the sequence storage path. Storage writes sequences; this block reads them in order and emits the Morse timing.
- Single clock, synchronous active-high reset.

---
 rtl/sequence_player_if.sv | 22 ++
 rtl/sequence_player.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sequence_player_if.sv
// Interface bundling the control/data handshake of sequence_player.
// master: the block driving load/abort and the storage image (storage side / bench).
// slave:  the sequence_player itself.
interface sequence_player_if;
    logic         load;
    logic [159:0] store_seqs;
    logic         abort;
    logic         tone;
    logic         busy;
    logic [3:0]   seq_index;
    logic         done;

    modport master (
        output load, store_seqs, abort,
        input  tone, busy, seq_index, done
    );

    modport slave (
        input  load, store_seqs, abort,
        output tone, busy, seq_index, done
    );
endinterface

// File: rtl/sequence_player.sv
// sequence_player: plays the 16-slot Morse sequence image (slot 15 first) as a
// timed on/off tone. Each slot holds five 2-bit symbols, MSB field first:
// 00 = dot, 01 = dash, 1x = end/empty.
//
// Build option: define REPEAT_PLAYBACK_EN to loop playback forever with a word
// gap instead of finishing with a done pulse.
//
// state    | meaning
// IDLE     | waiting for load; outputs quiet
// FETCH    | inspect slot ptr, skip empties (one slot per cycle)
// SYM_ON   | key down for one dot or dash
// SYM_GAP  | one silent unit between symbols of a sequence
// SEQ_GAP  | silent gap after a sequence
// DONE     | one-cycle done pulse
// WORD_GAP | extra silence before looping (REPEAT_PLAYBACK_EN only)
module sequence_player #(
    parameter int UNIT_CYCLES   = 4,
    parameter int DASH_UNITS    = 3,
    parameter int SEQ_GAP_UNITS = 3
) (
    input logic              clk,
    input logic              reset,
    sequence_player_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SYM_ON,
        SYM_GAP,
        SEQ_GAP,
        DONE,
        WORD_GAP
    } state_t;

    localparam int CW = $clog2(DASH_UNITS * UNIT_CYCLES) + 1;
    localparam logic [CW-1:0] DOT_LEN     = CW'(UNIT_CYCLES);
    localparam logic [CW-1:0] DASH_LEN    = CW'(DASH_UNITS * UNIT_CYCLES);
    localparam logic [CW-1:0] SEQ_GAP_LEN = CW'(SEQ_GAP_UNITS * UNIT_CYCLES);
`ifdef REPEAT_PLAYBACK_EN
    // Extra 4 units on top of the sequence gap gives the 7-unit word gap.
    localparam logic [CW-1:0] WORD_GAP_LEN = CW'(4 * UNIT_CYCLES);
`endif

    state_t        state;
    logic [159:0]  seq_buf;
    logic [3:0]    ptr;
    logic [9:0]    shifter;
    logic [2:0]    sym_cnt;
    logic [CW-1:0] cnt;
    logic          tone_q;
    logic          busy_q;
    logic          done_q;
    logic [7:0]    base;
    logic [9:0]    slot;

    assign base = {4'b0000, ptr} * 8'd10;
    assign slot = seq_buf[base +: 10];

    assign bus.tone      = tone_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.seq_index = ptr;

    // Playback sequencer: state, buffer, pointer, symbol shifter, unit timer and outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            seq_buf <= '1;
            ptr     <= 4'd15;
            shifter <= '1;
            sym_cnt <= '0;
            cnt     <= '0;
            tone_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != IDLE && bus.abort) begin
                state  <= IDLE;
                tone_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.load) begin
                            seq_buf <= bus.store_seqs;
                            ptr     <= 4'd15;
                            busy_q  <= 1'b1;
                            state   <= FETCH;
                        end
                    end
                    FETCH: begin
                        if (slot[9]) begin
                            if (ptr != 4'd0) begin
                                ptr <= ptr - 4'd1;
                            end else begin
`ifdef REPEAT_PLAYBACK_EN
                                cnt   <= WORD_GAP_LEN;
                                state <= WORD_GAP;
`else
                                done_q <= 1'b1;
                                state  <= DONE;
`endif
                            end
                        end else begin
                            shifter <= slot;
                            sym_cnt <= '0;
                            cnt     <= slot[8] ? DASH_LEN : DOT_LEN;
                            tone_q  <= 1'b1;
                            state   <= SYM_ON;
                        end
                    end
                    SYM_ON: begin
                        if (cnt == CW'(1)) begin
                            tone_q <= 1'b0;
                            // Field [7:6] is the next symbol; 1x or five consumed ends the sequence.
                            if (sym_cnt == 3'd4 || shifter[7]) begin
                                cnt   <= SEQ_GAP_LEN;
                                state <= SEQ_GAP;
                            end else begin
                                cnt   <= DOT_LEN;
                                state <= SYM_GAP;
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    SYM_GAP: begin
                        if (cnt == CW'(1)) begin
                            shifter <= {shifter[7:0], 2'b11};
                            sym_cnt <= sym_cnt + 3'd1;
                            cnt     <= shifter[6] ? DASH_LEN : DOT_LEN;
                            tone_q  <= 1'b1;
                            state   <= SYM_ON;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    SEQ_GAP: begin
                        if (cnt == CW'(1)) begin
                            if (ptr != 4'd0) begin
                                ptr   <= ptr - 4'd1;
                                state <= FETCH;
                            end else begin
`ifdef REPEAT_PLAYBACK_EN
                                cnt   <= WORD_GAP_LEN;
                                state <= WORD_GAP;
`else
                                done_q <= 1'b1;
                                state  <= DONE;
`endif
                            end
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                    DONE: begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
`ifdef REPEAT_PLAYBACK_EN
                    WORD_GAP: begin
                        if (cnt == CW'(1)) begin
                            ptr   <= 4'd15;
                            state <= FETCH;
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
`endif
                    default: begin
                        tone_q <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
